// File: rtl/credit_digit_driver.sv
// Binary credit to four BCD digits via a sequential double-dabble engine,
// with a double-buffered display register driving scanned seven-segment cathodes.
module credit_digit_driver #(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DP_POS = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] value,
   input  logic             load,
   input  logic [1:0]       S,
   input  logic             blank_lz,
   input  logic             dp_en,
   output logic [6:0]       SEG,
   output logic             DP,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned BCD_W = 16;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MAX_DISP = WIDTH'(9999);
   localparam logic [1:0]       DP_SEL   = 2'(DP_POS);

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [BCD_W-1:0]   disp_q, disp_d;
   logic               disp_ovf_q, disp_ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_adj;

   // Add 3 to every nibble that is 5 or more, ahead of each shift
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         disp_q     <= disp_d;
         disp_ovf_q <= disp_ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = CONV;
         CONV:    if (cnt_q == LAST_CNT) state_d = LATCH;
         LATCH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered status outputs
   always_comb begin
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      disp_d     = disp_q;
      disp_ovf_d = disp_ovf_q;
      bcd_adj    = add3(bcd_q);
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d = value;
               bcd_d = '0;
               cnt_d = '0;
               ovf_d = (value > MAX_DISP);
            end
         end
         CONV: begin
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + CNT_W'(1);
         end
         LATCH: begin
            disp_d     = bcd_q;
            disp_ovf_d = ovf_q;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_q == LATCH);
   end

   assign busy = busy_q;
   assign done = done_q;

   logic [3:0] digit;
   logic       hi_zero;
   logic       keep;
   logic       blank;

   // Cathode decode follows the scanner select with no added latency
   always_comb begin
      digit   = disp_q[{S, 2'b00} +: 4];
      hi_zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if ((2'(i) >= S) && (disp_q[4*i +: 4] != 4'd0)) hi_zero = 1'b0;
      end
      keep  = (S == 2'd0) || (dp_en && (S <= DP_SEL));
      blank = blank_lz && hi_zero && !keep;
      SEG   = 7'h7F;
      if (disp_ovf_q) begin
         SEG = 7'h7E;
      end else if (!blank) begin
         case (digit)
            4'd0:    SEG = 7'h01;
            4'd1:    SEG = 7'h4F;
            4'd2:    SEG = 7'h12;
            4'd3:    SEG = 7'h06;
            4'd4:    SEG = 7'h4C;
            4'd5:    SEG = 7'h24;
            4'd6:    SEG = 7'h20;
            4'd7:    SEG = 7'h0F;
            4'd8:    SEG = 7'h00;
            4'd9:    SEG = 7'h04;
            default: SEG = 7'h7F;
         endcase
      end
      DP = !(dp_en && (S == DP_SEL) && !disp_ovf_q);
   end

endmodule

// File: tb/tb_credit_digit_driver.sv
// Scoreboarded random/directed bench for credit_digit_driver against an
// arithmetic model of the displayed credit value.
module tb_credit_digit_driver;

   localparam int LAT = 15;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic [1:0]  S = '0;
   logic        blank_lz = 1'b0;
   logic        dp_en = 1'b0;
   logic [6:0]  SEG;
   logic        DP;
   logic        busy;
   logic        done;

   credit_digit_driver #(.WIDTH(14), .DP_POS(2)) dut (
      .clk(clk), .clr(clr), .value(value), .load(load), .S(S),
      .blank_lz(blank_lz), .dp_en(dp_en), .SEG(SEG), .DP(DP),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   m_busy = 0;
   int   m_disp = 0;
   int   checks = 0;
   int   errors = 0;
   bit   running = 1'b1;

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h01;  1: return 7'h4F;  2: return 7'h12;  3: return 7'h06;
         4: return 7'h4C;  5: return 7'h24;  6: return 7'h20;  7: return 7'h0F;
         8: return 7'h00;  9: return 7'h04;
         default: return 7'h7F;
      endcase
   endfunction

   // Expected {DP, SEG} for credit v shown on digit s
   function automatic logic [7:0] expect_out(input int v, input bit blz, input bit dpe, input int s);
      int  p10;
      bit  blank;
      p10 = 1;
      for (int i = 0; i < s; i++) p10 = p10 * 10;
      if (v > 9999) return {1'b1, 7'h7E};
      blank = blz && (s != 0) && !(dpe && s <= 2) && (v < p10);
      return {!(dpe && s == 2), blank ? 7'h7F : glyph((v / p10) % 10)};
   endfunction

   // Reference model: acceptance, busy window and expected done time
   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_busy <= 0;
      end else begin
         cyc <= cyc + 1;
         if (m_busy == 0 && load) begin
            q.push_back('{val: int'(value), cyc: cyc + 1 + LAT});
            m_busy <= LAT;
         end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
         end
      end
   end

   // Monitor: pops on done, then checks the displayed glyph and busy
   always @(negedge clk) begin
      if (running) begin
         logic [7:0] e;
         if (!clr) begin
            q.delete();
            m_disp = 0;
         end
         if (done) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected cyc=%0d got done=1 want 0", cyc);
            end else begin
               exp_t f;
               f = q.pop_front();
               m_disp = f.val;
               if (f.cyc != cyc) begin
                  errors++;
                  $display("FAIL done_time val=%0d got cyc=%0d want cyc=%0d", f.val, cyc, f.cyc);
               end
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t f;
            checks++;
            errors++;
            f = q.pop_front();
            m_disp = f.val;
            $display("FAIL done_missing val=%0d got done=0 want 1 at cyc=%0d", f.val, f.cyc);
         end
         e = expect_out(m_disp, blank_lz, dp_en, int'(S));
         checks++;
         if (SEG !== e[6:0]) begin
            errors++;
            $display("FAIL seg disp=%0d S=%0d blz=%0d dpe=%0d got %h want %h",
                     m_disp, S, blank_lz, dp_en, SEG, e[6:0]);
         end
         checks++;
         if (DP !== e[7]) begin
            errors++;
            $display("FAIL dp disp=%0d S=%0d dpe=%0d got %b want %b", m_disp, S, dp_en, DP, e[7]);
         end
         checks++;
         if (busy !== (m_busy != 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, (m_busy != 0));
         end
      end
   end

   // Anode scanner stand-in: new digit select every cycle
   always @(posedge clk) begin
      #1 S = 2'($urandom_range(0, 3));
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v);
      value = 14'(v);
      load  = 1'b1;
      wait_cyc(1);
      load  = 1'b0;
   endtask

   initial begin
      clr = 1'b0;
      wait_cyc(3);
      blank_lz = 1'b1;
      wait_cyc(3);
      clr = 1'b1;
      blank_lz = 1'b0;
      wait_cyc(2);

      do_load(1234);
      wait_cyc(LAT + 4);

      blank_lz = 1'b1;
      dp_en    = 1'b1;
      do_load(50);
      wait_cyc(LAT + 4);

      blank_lz = 1'b0;
      dp_en    = 1'b0;
      do_load(9999);
      wait_cyc(4);
      do_load(1);
      wait_cyc(LAT + 2);

      blank_lz = 1'b1;
      dp_en    = 1'b1;
      do_load(10000);
      wait_cyc(LAT + 2);
      dp_en = 1'b0;
      do_load(7);
      wait_cyc(LAT + 3);

      do_load(4321);
      wait_cyc(6);
      clr = 1'b0;
      wait_cyc(2);
      clr = 1'b1;
      do_load(8);
      wait_cyc(LAT + 2);

      // back-to-back loads held high
      value = 14'(16383);
      load  = 1'b1;
      wait_cyc(2 * (LAT + 1) + 1);
      load  = 1'b0;
      wait_cyc(LAT + 2);

      for (int i = 0; i < 3000; i++) begin
         blank_lz = 1'($urandom);
         dp_en    = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       value = 14'($urandom_range(0, 120));
            1:       value = 14'($urandom_range(9990, 16383));
            default: value = 14'($urandom_range(0, 9999));
         endcase
         load = ($urandom_range(0, 7) == 0);
         wait_cyc(1);
      end
      load = 1'b0;
      wait_cyc(LAT + 4);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_done got %0d outstanding want 0", q.size());
      end
      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/credit_digit_driver.md
# credit_digit_driver

Converts the machine's binary credit value into four BCD digits with a sequential double-dabble engine. It drives the active-low seven-segment cathodes for whichever digit the anode scanner currently selects. The block sits directly downstream of the anode scanner and consumes its 2-bit digit select `S`, so cathodes and anodes always change together. The displayed value is double-buffered, so the display never shows a partially converted result.

## Interface
- `WIDTH`, 14, width of the binary input; the legal display range is 0..9999.
- `DP_POS`, 2, digit index (0 = rightmost) whose decimal point is lit when `dp_en` = 1.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `clr`  input  1  asynchronous, active-low reset.
- `value`  input  WIDTH  binary credit in cents; sampled only on an accepted `load`.
- `load`  input  1  request to convert `value`; accepted only while idle.
- `S`  input  2  digit select from the anode scanner (0 = ones … 3 = thousands).
- `blank_lz`  input  1  enables leading-zero blanking.
- `dp_en`  input  1  enables the decimal point at `DP_POS`.
- `SEG`  output  7  active-low cathodes; `SEG[6:0]` = a,b,c,d,e,f,g.
- `DP`  output  1  active-low decimal point.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when the display register updates.

## Operation
- FSM states:
  - IDLE: if `load`=1, capture `value` into the shift register, clear the BCD accumulator, clear the bit counter, capture `ovf` = (`value` > 9999), and go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble that is ≥ 5, then shift {bcd, bin} left by 1. The counter increments; after WIDTH shifts go to LATCH.
  - LATCH: copy the 4 nibbles and `ovf` into the display register, assert `done`, and go to IDLE.
- `busy` = 1 in CONV and LATCH. `load` is ignored in CONV and LATCH, with no queueing.
- The display register holds the previous result during conversion.
- `SEG`/`DP` are combinational from `S` and the display register, not from the conversion engine.
- Digit glyphs, active-low abcdefg:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04 (hex).
  - Dash = 7E; blank = 7F.
- Overflow (stored `ovf`=1): every digit shows a dash, `DP`=1, and `blank_lz` is ignored.
- Leading-zero blanking (`blank_lz`=1, no overflow):
  - Digit i is blank if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - When `dp_en`=1, digits ≤ `DP_POS` are never blanked.
- `DP` = 0 only when `dp_en`=1, `S`==`DP_POS` and there is no overflow; otherwise `DP` = 1.

## Timing
- Reset (`clr`=0, asynchronous):
  - State IDLE, display digits = 0, `ovf`=0, `busy`=0, `done`=0, counter and shift registers = 0.
  - Reset during CONV aborts the conversion with no `done`; the display shows 0.
- Latency:
  - `load` is sampled at edge k.
  - `busy` is 1 from after edge k.
  - Shifts occur on edges k+1 … k+WIDTH.
  - The display register updates at edge k+WIDTH+1, and `done`=1 for that cycle.
  - `busy` falls after edge k+WIDTH+1, so a load-to-display latency of 15 cycles at WIDTH=14.
- `load`=1 in the first IDLE cycle after LATCH is accepted (back-to-back conversions: a new `done` every 16 cycles).
- A change on `S` is reflected on `SEG`/`DP` in the same cycle, with zero latency.
- The BCD accumulator is 16 bits; the add-3 step is applied before each shift, including the first; `bin` shifts in zeros.

## Test plan
- Reset: hold `clr`=0, `S`=0 → `SEG`=01, `busy`=0, `done`=0. With `blank_lz`=1, `S`=1 → `SEG`=7F.
- Load 1234 with `blank_lz`=0 → `busy` high 15 cycles, a single `done` at cycle 15. Then `S`=3/2/1/0 → `SEG`=4F/12/06/4C.
- Load 50 with `blank_lz`=1, `dp_en`=1 →
  - `S`=3 gives 7F.
  - `S`=2 gives 01 with `DP`=0.
  - `S`=1 gives 24; `S`=0 gives 01.
  - During the conversion, the old value stays displayed.
- Load 9999, then pulse `load` with `value`=1 at cycle 5 → the second load is ignored; all digits show 04; exactly one `done`.
- Load 10000 with `blank_lz`=1, `dp_en`=1 → every `S` gives `SEG`=7E, `DP`=1. A later load of 7 → `S`=0 gives 0F and `S`=3 gives 7F.
- Drop `clr` to 0 at cycle 7 of a conversion of 4321 → `busy`=0 at once, `SEG`=01 at `S`=0, no `done`. After release, loading 8 → `S`=0 gives 00 after 15 cycles.
